// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: single-word data-memory read channel for the writeback load path.
interface regfile_writeback_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  modport master (output mem_req, mem_addr, input mem_rdata, mem_rvalid);
  modport slave  (input mem_req, mem_addr, output mem_rdata, mem_rvalid);
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: register-file write port driver with load path (lane extract + extend).
// Define WB_LOAD_TIMEOUT_EN to abort a load after TIMEOUT_CYCLES wait cycles with a wb_err pulse.
module regfile_writeback #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [31:0]                inst,
  input  logic                       inst_valid,
  input  logic [31:0]                alu_result,
  input  logic [31:0]                pc,
  regfile_writeback_if.master        mem,
  output logic [31:0]                write_data,
  output logic                       RegWrite,
  output logic [4:0]                 wb_rd,
  output logic                       busy,
  output logic                       wb_err
);
  typedef enum logic [1:0] {IDLE, WRITE, LOAD_WAIT} state_t;
  state_t      state;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [6:0]  op;
  logic [31:0] uimm, dec_data, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        dec_wr, dec_ld, accept;
  always_comb begin
    op       = inst[6:0];
    uimm     = {inst[31:12], 12'b0};
    dec_ld   = op == 7'b0000011;
    dec_wr   = op inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    dec_data = (op == 7'b1101111 || op == 7'b1100111) ? pc + 32'd4 :
               op == 7'b0110111 ? uimm :
               op == 7'b0010111 ? pc + uimm : alu_result;
    ld_byte  = mem.mem_rdata[{addr_lo, 3'b000} +: 8];
    ld_half  = addr_lo[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    ld_data  = funct3 == 3'b000 ? {{24{ld_byte[7]}}, ld_byte} :
               funct3 == 3'b100 ? {24'b0, ld_byte} :
               funct3 == 3'b001 ? {{16{ld_half[15]}}, ld_half} :
               funct3 == 3'b101 ? {16'b0, ld_half} : mem.mem_rdata;
    // the response is not accepted in the same cycle the request is on the bus
    accept   = state == LOAD_WAIT && !mem.mem_req && mem.mem_rvalid;
  end
  assign busy = state == LOAD_WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt;
`else
  assign wb_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      write_data   <= '0;
      RegWrite     <= 1'b0;
      wb_rd        <= '0;
      funct3       <= '0;
      addr_lo      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      cnt          <= '0;
      wb_err       <= 1'b0;
`endif
    end else begin
      RegWrite    <= 1'b0;
      mem.mem_req <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      wb_err      <= 1'b0;
`endif
      if (state == LOAD_WAIT) begin
        if (accept) begin
          state      <= WRITE;
          write_data <= ld_data;
          RegWrite   <= wb_rd != 5'd0;
        end
`ifdef WB_LOAD_TIMEOUT_EN
        else if (cnt == TMAX) begin
          state  <= IDLE;
          wb_err <= 1'b1;
        end else cnt <= cnt + 16'd1;
`endif
      end else if (inst_valid && dec_wr) begin
        state      <= WRITE;
        write_data <= dec_data;
        wb_rd      <= inst[11:7];
        RegWrite   <= inst[11:7] != 5'd0;
      end else if (inst_valid && dec_ld) begin
        state        <= LOAD_WAIT;
        wb_rd        <= inst[11:7];
        funct3       <= inst[14:12];
        addr_lo      <= alu_result[1:0];
        mem.mem_addr <= {alu_result[31:2], 2'b00};
        mem.mem_req  <= 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
        cnt          <= '0;
`endif
      end else state <= IDLE;
    end
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-side counterpart of the register file / immediate generator: takes the instruction currently presented to the register file together with the ALU result and PC, and produces the `write_data` / `RegWrite` pair that drives the register file's write port. It also runs the load path: it issues a single-word memory read, waits for the response, and performs byte/half extraction and sign or zero extension before writeback. It sits between the ALU/data-memory side and the register file.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: maximum `LOAD_WAIT` cycles before abort (1..65535). Used only with `WB_LOAD_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction being retired.
- `inst_valid` in 1: `inst`, `alu_result` and `pc` are valid this cycle.
- `alu_result` in 32: ALU output; this is the effective address for loads.
- `pc` in 32: PC of `inst`.
- `mem_rdata` in 32: word read from data memory.
- `mem_rvalid` in 1: `mem_rdata` is valid this cycle.
- `mem_req` out 1: one-cycle read request pulse.
- `mem_addr` out 32: word-aligned read address, `{addr[31:2],2'b00}`.
- `write_data` out 32: register-file write data.
- `RegWrite` out 1: register-file write enable.
- `wb_rd` out 5: destination register, latched from `inst[11:7]`.
- `busy` out 1: high in `LOAD_WAIT`; upstream must stall.
- `wb_err` out 1: one-cycle pulse on load timeout.

## Operation
Reset values:
- `write_data`, `mem_addr`: 0.
- `wb_rd`: 0.
- `RegWrite`, `mem_req`, `busy`, `wb_err`: 0.
- State: `IDLE`.

States: `IDLE`, `WRITE`, `LOAD_WAIT`. `inst_valid` is sampled in `IDLE` and `WRITE` and ignored in `LOAD_WAIT`.

Decode on an accepted `inst_valid`, by opcode `inst[6:0]`:
- `0110011` (R-type), `0010011` (I-ALU): go to `WRITE`; data = `alu_result`.
- `1101111` (JAL), `1100111` (JALR): go to `WRITE`; data = `pc + 4` (mod 2^32).
- `0110111` (LUI): go to `WRITE`; data = `{inst[31:12],12'b0}`.
- `0010111` (AUIPC): go to `WRITE`; data = `pc + {inst[31:12],12'b0}`.
- `0000011` (load): go to `LOAD_WAIT`. Latch `funct3 = inst[14:12]`, `addr[1:0] = alu_result[1:0]` and `rd`. Set `mem_addr` and pulse `mem_req` in the first `LOAD_WAIT` cycle.
- Any other opcode (store, branch, unknown): no write; go to `IDLE`.

`WRITE` behaviour:
- `RegWrite` is 1 for exactly this cycle, unless the latched rd = 0. In that case `RegWrite` = 0 but `write_data` and `wb_rd` still update.
- A new `inst_valid` in `WRITE` is decoded as in `IDLE`, giving back-to-back writes at one per cycle.
- With no new `inst_valid`, return to `IDLE`.

`LOAD_WAIT` behaviour:
- `mem_rvalid` is ignored in the `mem_req` cycle and accepted in any later cycle.
- On accept, go to `WRITE` with data from lane extraction:
  - LB (000): sign-extend `mem_rdata[8*addr+7 : 8*addr]`.
  - LBU (100): zero-extend the same byte.
  - LH (001): sign-extend the half selected by `addr[1]`.
  - LHU (101): zero-extend the same half.
  - LW (010): the full word, with `addr[1:0]` ignored.
  - Other funct3 values: treated as LW.
- A load to x0 still issues `mem_req` and suppresses `RegWrite`.

## Timing
- Non-load write latency: `RegWrite` is high 1 cycle after the accepted `inst_valid` edge.
- Load latency:
  - `mem_req` is high 1 cycle after accept.
  - `RegWrite` is high 1 cycle after the accepted `mem_rvalid`.
  - Minimum total is 3 cycles from accept.
- `busy` equals (state == `LOAD_WAIT`), decoded combinationally from the registered state.
- All outputs except `busy` are registered.
- Reset asserted mid-load clears the state asynchronously. A `mem_rvalid` arriving later in `IDLE` is ignored and produces no write.
- `mem_rvalid` outside `LOAD_WAIT` is always ignored.

## Configuration
- `WB_LOAD_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to `LOAD_WAIT` and increments each `LOAD_WAIT` cycle without an accept.
  - When it reaches `TIMEOUT_CYCLES`, go to `IDLE`, pulse `wb_err` for 1 cycle, and perform no write.
  - `mem_rvalid` arriving in that same cycle wins: normal writeback, no error.
- `WB_LOAD_TIMEOUT_EN` undefined: `LOAD_WAIT` waits indefinitely, no counter is built, and `wb_err` is tied 0.

## Test plan
- Reset: `rst`=0 mid-simulation, checked asynchronously with no clock edge → all outputs 0 and state `IDLE`.
- ADD x5, `alu_result`=0x0000_1234 → next cycle `RegWrite`=1, `wb_rd`=5, `write_data`=0x0000_1234; `RegWrite` is 1 for one cycle only.
- JAL x1 at `pc`=0x0000_0100 followed by LUI x2 with `inst[31:12]`=0xABCDE on consecutive cycles → writes 0x0000_0104 then 0xABCD_E000 on consecutive cycles.
- LB x3, `alu_result`=0x0000_2003, `mem_rdata`=0x80FF_FFFF returned 4 cycles after `mem_req`:
  - `mem_addr`=0x0000_2000.
  - `busy`=1 throughout the wait.
  - Then `write_data`=0xFFFF_FF80; LBU gives 0x0000_0080.
- ADDI x0, `alu_result`=7 → `RegWrite`=0, `write_data`=7. LHU x4 with addr[1]=1, `mem_rdata`=0x8001_0000 → 0x0000_8001.
- With `WB_LOAD_TIMEOUT_EN` defined and `TIMEOUT_CYCLES`=8, LW with no `mem_rvalid` → `wb_err` pulses after 8 wait cycles and there is no `RegWrite`. A late `mem_rvalid` after the abort is ignored.
